sram_arbiter: RTL

- Two-port arbiter and access sequencer for the single shared SRAM/Mem2IO data port.
- Port 0 is the CPU, driven by the ISDU memory states with MAR/MDR. Port 1 is a program-loader/debug requester that fills or dumps SRAM while the CPU is halted or interleaved.
- Grants one request at a time with round-robin fairness and sequences OE/WE through a fixed number of wait cycles.
- Returns read data and a one-cycle ack to the winning requester.

---
 rtl/sram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter and OE/WE access sequencer for a shared SRAM
//
// Purpose:
//   Arbitrates between the CPU (port 0) and a loader/debug requester (port 1)
//   for the single SRAM data port. One access runs at a time: IDLE -> ACCESS
//   (OE or WE held low for WAIT_CYCLES) -> DONE (recovery + one-cycle ack).
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0, ack0   CPU request channel
//   req1/we1/addr1/wdata1, ack1   loader request channel
//   rdata               read data of the last completed read
//   ADDR, Data_to_SRAM  SRAM address / write data, registered at grant
//   Data_from_SRAM      SRAM read data
//   OE, WE              active-low SRAM strobes
//   busy                high whenever the sequencer is not idle
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] Data_to_SRAM,
  input  logic [DW-1:0] Data_from_SRAM,
  output logic          OE,
  output logic          WE,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_last;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic          w_grant;

  // On a tie the port that did not win last time gets the grant; otherwise
  // whichever single port is requesting wins.
  assign w_any   = req0 | req1;
  assign w_grant = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win   <= w_grant;
            r_last  <= w_grant;
            r_we    <= w_grant ? we1 : we0;
            r_addr  <= w_grant ? addr1 : addr0;
            r_wdata <= w_grant ? wdata1 : wdata0;
            r_cnt   <= CNT_INIT;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            // Capture on the edge that ends the OE-low window, while the
            // SRAM is still driving the bus.
            if (!r_we) begin
              r_rdata <= Data_from_SRAM;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes come only from registered state, so an asynchronous reset
  // releases them immediately and they can never be low together.
  assign OE           = ~((r_state == ST_ACCESS) & ~r_we);
  assign WE           = ~((r_state == ST_ACCESS) & r_we);
  assign ack0         = (r_state == ST_DONE) & ~r_win;
  assign ack1         = (r_state == ST_DONE) & r_win;
  assign busy         = (r_state != ST_IDLE);
  assign ADDR         = r_addr;
  assign Data_to_SRAM = r_wdata;
  assign rdata        = r_rdata;

endmodule
